// File: rtl/scmi_mbox_arbiter.sv
// Round-robin owner arbiter for a shared SCMI mailbox channel.
// Grants one agent at a time. Tracks the doorbell -> completion handshake.
// Routes the completion pulse to the owner only. A watchdog recovers the
// channel if the platform never completes.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | channel free, arbitrating among requesters
// S_GRANTED    | owner holds channel, doorbell not yet rung (may still abort)
// S_WAIT_COMPL | doorbell rung, waiting for completion or watchdog expiry
// S_DONE       | transaction finished (err_o tells how), waiting for release
module scmi_mbox_arbiter #(
   parameter int unsigned NUM_AGENTS     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned IDX_W          = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1,
   parameter int unsigned CNT_W          = ($clog2(TIMEOUT_CYCLES + 1) > 1) ?
                                           $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_AGENTS-1:0] req_i,
   input  logic [NUM_AGENTS-1:0] release_i,
   input  logic                  doorbell_irq_i,
   input  logic                  completion_irq_i,
   output logic [NUM_AGENTS-1:0] gnt_o,
   output logic                  owner_valid_o,
   output logic [IDX_W-1:0]      owner_o,
   output logic [NUM_AGENTS-1:0] completion_irq_o,
   output logic                  timeout_o,
   output logic                  err_o,
   output logic                  spurious_o
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_GRANTED    = 2'd1,
      S_WAIT_COMPL = 2'd2,
      S_DONE       = 2'd3
   } state_e;

   // A zero timeout disables the watchdog; the counter then just free-runs.
   localparam bit              WDOG_EN  = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AGENTS - 1);

   state_e                  state_q, state_d;
   logic [NUM_AGENTS-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic                    owner_valid_q, owner_valid_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_AGENTS-1:0]   cpl_q, cpl_d;
   logic                    timeout_q, timeout_d;
   logic                    err_q, err_d;
   logic                    spurious_q, spurious_d;

   logic                    pick_valid;
   logic [IDX_W-1:0]        pick_idx;
   logic [IDX_W-1:0]        cand;
   logic                    rel_own;

   // Round-robin search: first requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
         cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_AGENTS);
         if (!pick_valid && req_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Only the current owner's release bit matters; others are ignored.
   assign rel_own = release_i[owner_q];

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      rr_ptr_d      = rr_ptr_q;
      cnt_d         = cnt_q;
      cpl_d         = '0;
      timeout_d     = 1'b0;
      err_d         = err_q;
      spurious_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            spurious_d = doorbell_irq_i | completion_irq_i;
            if (pick_valid) begin
               state_d           = S_GRANTED;
               gnt_d             = '0;
               gnt_d[pick_idx]   = 1'b1;
               owner_d           = pick_idx;
               owner_valid_d     = 1'b1;
               rr_ptr_d          = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
            end
         end

         S_GRANTED: begin
            spurious_d = completion_irq_i;
            // Doorbell takes priority over a same-cycle abort.
            if (doorbell_irq_i) begin
               state_d = S_WAIT_COMPL;
               cnt_d   = '0;
            end else if (rel_own) begin
               state_d       = S_IDLE;
               gnt_d         = '0;
               owner_d       = '0;
               owner_valid_d = 1'b0;
            end
         end

         S_WAIT_COMPL: begin
            spurious_d = doorbell_irq_i;
            cnt_d      = cnt_q + CNT_W'(1);
            // Completion beats a same-cycle watchdog expiry.
            if (completion_irq_i) begin
               state_d = S_DONE;
               cpl_d   = gnt_q;
               err_d   = 1'b0;
            end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
               err_d     = 1'b1;
            end
         end

         S_DONE: begin
            spurious_d = doorbell_irq_i | completion_irq_i;
            if (rel_own) begin
               state_d       = S_IDLE;
               gnt_d         = '0;
               owner_d       = '0;
               owner_valid_d = 1'b0;
               err_d         = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         gnt_q         <= '0;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         rr_ptr_q      <= '0;
         cnt_q         <= '0;
         cpl_q         <= '0;
         timeout_q     <= 1'b0;
         err_q         <= 1'b0;
         spurious_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         rr_ptr_q      <= rr_ptr_d;
         cnt_q         <= cnt_d;
         cpl_q         <= cpl_d;
         timeout_q     <= timeout_d;
         err_q         <= err_d;
         spurious_q    <= spurious_d;
      end
   end

   assign gnt_o            = gnt_q;
   assign owner_valid_o    = owner_valid_q;
   assign owner_o          = owner_q;
   assign completion_irq_o = cpl_q;
   assign timeout_o        = timeout_q;
   assign err_o            = err_q;
   assign spurious_o       = spurious_q;

endmodule

// File: tb/tb_scmi_mbox_arbiter.sv
// Directed bench for scmi_mbox_arbiter (4 agents, 16-cycle watchdog).
module tb_scmi_mbox_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [3:0] req_i;
   logic [3:0] release_i;
   logic       doorbell_irq_i;
   logic       completion_irq_i;
   logic [3:0] gnt_o;
   logic       owner_valid_o;
   logic [1:0] owner_o;
   logic [3:0] completion_irq_o;
   logic       timeout_o;
   logic       err_o;
   logic       spurious_o;

   int n_vec = 0;
   int n_bad = 0;

   scmi_mbox_arbiter #(
      .NUM_AGENTS     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_i            (req_i),
      .release_i        (release_i),
      .doorbell_irq_i   (doorbell_irq_i),
      .completion_irq_i (completion_irq_i),
      .gnt_o            (gnt_o),
      .owner_valid_o    (owner_valid_o),
      .owner_o          (owner_o),
      .completion_irq_o (completion_irq_o),
      .timeout_o        (timeout_o),
      .err_o            (err_o),
      .spurious_o       (spurious_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string      name;
      logic [3:0] req;
      logic [3:0] rel;
      logic       db;
      logic       cpl;
      int         n;
      logic [3:0] e_gnt;
      logic       e_ov;
      logic [1:0] e_own;
      logic [3:0] e_cpl;
      logic       e_to;
      logic       e_err;
      logic       e_sp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic [3:0] req, input logic [3:0] rel,
                               input logic db, input logic cpl, input int n,
                               input logic [3:0] e_gnt, input logic e_ov, input logic [1:0] e_own,
                               input logic [3:0] e_cpl, input logic e_to, input logic e_err,
                               input logic e_sp);
      vec_t v;
      v.name = name; v.req = req; v.rel = rel; v.db = db; v.cpl = cpl; v.n = n;
      v.e_gnt = e_gnt; v.e_ov = e_ov; v.e_own = e_own; v.e_cpl = e_cpl;
      v.e_to = e_to; v.e_err = e_err; v.e_sp = e_sp;
      return v;
   endfunction

   // owner_o is only meaningful while owner_valid_o is expected high.
   task automatic check_outputs(input string name, input logic [3:0] e_gnt, input logic e_ov,
                                input logic [1:0] e_own, input logic [3:0] e_cpl,
                                input logic e_to, input logic e_err, input logic e_sp);
      logic [13:0] act;
      logic [13:0] exp;
      act = {gnt_o, owner_valid_o, (e_ov ? owner_o : 2'b00), completion_irq_o,
             timeout_o, err_o, spurious_o};
      exp = {e_gnt, e_ov, (e_ov ? e_own : 2'b00), e_cpl, e_to, e_err, e_sp};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got gnt=%b ov=%b own=%0d cpl=%b to=%b err=%b sp=%b, want gnt=%b ov=%b own=%0d cpl=%b to=%b err=%b sp=%b",
                  name, gnt_o, owner_valid_o, owner_o, completion_irq_o, timeout_o, err_o,
                  spurious_o, e_gnt, e_ov, e_own, e_cpl, e_to, e_err, e_sp);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] rel, input logic db,
                        input logic cpl);
      req_i            = req;
      release_i        = rel;
      doorbell_irq_i   = db;
      completion_irq_i = cpl;
   endtask

   initial begin
      //                 name            req      rel      db cpl n    gnt      ov own    cpl_o   to err sp
      vecs.push_back(mk("grant0",        4'b0101, 4'b0000, 0, 0, 1,  4'b0001, 1, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("rel0_abort",    4'b0101, 4'b0001, 0, 0, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("grant2_rr",     4'b0101, 4'b0000, 0, 0, 1,  4'b0100, 1, 2'd2, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("rel_nonowner",  4'b0000, 4'b0001, 0, 0, 1,  4'b0100, 1, 2'd2, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("rel2",          4'b0000, 4'b0100, 0, 0, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("grant1",        4'b0010, 4'b0000, 0, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("db1",           4'b0000, 4'b0000, 1, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("rel_in_wait",   4'b0000, 4'b0010, 0, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("wait1",         4'b0000, 4'b0000, 0, 0, 8,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("cpl1",          4'b0000, 4'b0000, 0, 1, 1,  4'b0010, 1, 2'd1, 4'b0010, 0, 0, 0));
      vecs.push_back(mk("cpl1_1cyc",     4'b0000, 4'b0000, 0, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("db_in_done",    4'b0000, 4'b0000, 1, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("rel1",          4'b0000, 4'b0010, 0, 0, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("db_in_idle",    4'b0000, 4'b0000, 1, 0, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("cpl_in_idle",   4'b0000, 4'b0000, 0, 1, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("grant3",        4'b1000, 4'b0000, 0, 0, 1,  4'b1000, 1, 2'd3, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("db3",           4'b0000, 4'b0000, 1, 0, 1,  4'b1000, 1, 2'd3, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("wait3_15",      4'b0000, 4'b0000, 0, 0, 15, 4'b1000, 1, 2'd3, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("expire3",       4'b0000, 4'b0000, 0, 0, 1,  4'b1000, 1, 2'd3, 4'b0000, 1, 1, 0));
      vecs.push_back(mk("expire3_1cyc",  4'b0000, 4'b0000, 0, 0, 1,  4'b1000, 1, 2'd3, 4'b0000, 0, 1, 0));
      vecs.push_back(mk("late_cpl",      4'b0000, 4'b0000, 0, 1, 1,  4'b1000, 1, 2'd3, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("rel3_clr_err",  4'b0000, 4'b1000, 0, 0, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("grant0_wrap",   4'b0001, 4'b0000, 0, 0, 1,  4'b0001, 1, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("db0",           4'b0000, 4'b0000, 1, 0, 1,  4'b0001, 1, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("wait0_15",      4'b0000, 4'b0000, 0, 0, 15, 4'b0001, 1, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("cpl_at_expiry", 4'b0000, 4'b0000, 0, 1, 1,  4'b0001, 1, 2'd0, 4'b0001, 0, 0, 0));
      vecs.push_back(mk("rel0",          4'b0000, 4'b0001, 0, 0, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("grant1b",       4'b0010, 4'b0000, 0, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("cpl_in_grant",  4'b0000, 4'b0000, 0, 1, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("db_and_rel",    4'b0000, 4'b0010, 1, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("wait1b",        4'b0000, 4'b0000, 0, 0, 1,  4'b0010, 1, 2'd1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("cpl1b",         4'b0000, 4'b0000, 0, 1, 1,  4'b0010, 1, 2'd1, 4'b0010, 0, 0, 0));
      vecs.push_back(mk("rel1b",         4'b0000, 4'b0010, 0, 0, 1,  4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0));

      rst_ni = 1'b0;
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      repeat (3) @(negedge clk_i);
      check_outputs("reset_state", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      rst_ni = 1'b1;

      foreach (vecs[k]) begin
         for (int c = 0; c < vecs[k].n; c++) begin
            @(negedge clk_i);
            drive(vecs[k].req, vecs[k].rel, vecs[k].db, vecs[k].cpl);
            @(posedge clk_i);
            #1;
            check_outputs($sformatf("%s[%0d]", vecs[k].name, c), vecs[k].e_gnt, vecs[k].e_ov,
                          vecs[k].e_own, vecs[k].e_cpl, vecs[k].e_to, vecs[k].e_err,
                          vecs[k].e_sp);
         end
      end

      // Asynchronous reset while waiting for completion (rr_ptr is 2 here).
      @(negedge clk_i);
      drive(4'b0100, 4'b0000, 1'b0, 1'b0);
      @(negedge clk_i);
      drive(4'b0000, 4'b0000, 1'b1, 1'b0);
      @(negedge clk_i);
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      check_outputs("pre_reset_wait", 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      check_outputs("async_reset", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // All agents requesting after reset: order 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         logic [3:0] e_gnt;
         e_gnt = 4'b0001 << (k % 4);
         @(negedge clk_i);
         drive(4'b1111, 4'b0000, 1'b0, 1'b0);
         @(posedge clk_i);
         #1;
         check_outputs($sformatf("rr_grant%0d", k), e_gnt, 1'b1, 2'(k % 4), 4'b0000,
                       1'b0, 1'b0, 1'b0);
         @(negedge clk_i);
         drive(4'b1111, e_gnt, 1'b0, 1'b0);
         @(posedge clk_i);
         #1;
         check_outputs($sformatf("rr_release%0d", k), 4'b0000, 1'b0, 2'd0, 4'b0000,
                       1'b0, 1'b0, 1'b0);
      end

      @(negedge clk_i);
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/scmi_mbox_arbiter.md
# scmi_mbox_arbiter

Shares one SCMI mailbox channel between `NUM_AGENTS` requesting agents. It grants exclusive ownership round-robin and tracks the doorbell → completion exchange. It routes the completion interrupt back to the owning agent only, and recovers the channel with a watchdog when the platform never completes. It sits between the agents' software interrupt and handshake lines and the `doorbell_irq_o` and `completion_irq_o` pulses of the AXI-lite SCMI mailbox.

## Interface
- `NUM_AGENTS`, default 4: number of requesters; at least 1.
- `TIMEOUT_CYCLES`, default 1024: cycles allowed in WAIT_COMPL before forced recovery; 0 disables the watchdog.
- `IDX_W`, default `max(1, $clog2(NUM_AGENTS))`: owner index width (derived).
- `CNT_W`, default `max(1, $clog2(TIMEOUT_CYCLES+1))`: watchdog counter width (derived).
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, `NUM_AGENTS`: level request for channel ownership.
- `release_i`, in, `NUM_AGENTS`: 1-cycle pulse; the agent gives up the channel.
- `doorbell_irq_i`, in, 1: 1-cycle pulse from the mailbox; the owner rang the doorbell.
- `completion_irq_i`, in, 1: 1-cycle pulse from the mailbox; the platform completed.
- `gnt_o`, out, `NUM_AGENTS`: one-hot grant, held while the agent owns the channel.
- `owner_valid_o`, out, 1: channel owned.
- `owner_o`, out, `IDX_W`: index of the owner; valid only when `owner_valid_o` is 1.
- `completion_irq_o`, out, `NUM_AGENTS`: completion pulse routed to the owner.
- `timeout_o`, out, 1: 1-cycle pulse; the watchdog expired.
- `err_o`, out, 1: the last transaction ended by timeout; held until release.
- `spurious_o`, out, 1: 1-cycle pulse; a doorbell or completion arrived in an illegal state.

## Operation
- FSM states: IDLE, GRANTED, WAIT_COMPL, DONE. Reset state is IDLE.
- **IDLE**
  - If any `req_i` bit is set, pick the first requester at or after `rr_ptr`, wrapping modulo `NUM_AGENTS`.
  - Register `gnt_o`, `owner_o` and `owner_valid_o`.
  - Set `rr_ptr = winner+1`, wrapping to 0 after `NUM_AGENTS-1`.
  - Go to GRANTED.
- **GRANTED**
  - `doorbell_irq_i` → WAIT_COMPL; the watchdog counter is cleared to 0.
  - `release_i[owner]` → IDLE (abort before doorbell). `err_o` stays 0.
  - If both arrive in the same cycle, the doorbell wins and the release is ignored.
- **WAIT_COMPL**
  - The counter increments every cycle.
  - `completion_irq_i` → DONE with `err_o`=0, and `completion_irq_o[owner]` pulses for 1 cycle.
  - If the counter reaches `TIMEOUT_CYCLES-1` with no completion → DONE with `err_o`=1, `timeout_o` pulses, and no `completion_irq_o` pulse.
  - If completion and expiry occur in the same cycle, completion wins.
  - `release_i` is ignored in this state: an agent cannot abort after ringing the doorbell.
- **DONE**
  - `release_i[owner]` → IDLE. `gnt_o`, `owner_valid_o` and `err_o` clear.
- `release_i` bits from non-owners are ignored in every state.
- Deasserting `req_i` has no effect after grant; only `release_i` frees the channel.
- `spurious_o` pulses for:
  - `doorbell_irq_i` in IDLE, WAIT_COMPL or DONE;
  - `completion_irq_i` in IDLE, GRANTED or DONE.
  
  State is otherwise unchanged.
- Reset mid-operation: all state and outputs return to reset values immediately. Any pending completion is lost.
- Reset values of all outputs are 0. `rr_ptr` resets to 0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Grant latency: `req_i` sampled high in IDLE at edge t → `gnt_o` high after edge t.
- At least 1 cycle of IDLE separates consecutive owners: release at edge t → IDLE after t → next grant after t+1.
- `completion_irq_o`, `timeout_o` and `spurious_o` pulses appear 1 cycle after the causing input and last exactly 1 cycle.
- Worst-case WAIT_COMPL residency is `TIMEOUT_CYCLES` cycles (if `TIMEOUT_CYCLES` > 0).

## Test plan
- Reset, then `req_i`=4'b0101 → `gnt_o`=4'b0001 and `owner_o`=0 one cycle later. After release, `gnt_o`=4'b0100 and `owner_o`=2.
- Owner 1: doorbell, then completion 10 cycles later → `completion_irq_o`=4'b0010 for exactly 1 cycle, `err_o`=0. After `release_i[1]`, the FSM is in IDLE.
- `TIMEOUT_CYCLES`=16: doorbell with no completion → `timeout_o` pulses 16 cycles after entering WAIT_COMPL, `err_o`=1, no `completion_irq_o`. A late completion afterwards → `spurious_o`=1.
- Completion and watchdog expiry in the same cycle → `completion_irq_o` pulses, `timeout_o` stays 0.
- `release_i` from a non-owner, and `release_i` from the owner during WAIT_COMPL → grant unchanged. A doorbell in IDLE → `spurious_o`, FSM stays in IDLE.
- Assert `rst_ni`=0 during WAIT_COMPL → all outputs 0 asynchronously. With all four agents requesting after reset, the grant order is 0,1,2,3,0.
